// File: rtl/dmem_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder_pkg                                           |
// | Description : Shared size codes and FSM encoding for the data-memory       |
// |               responder.                                                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package dmem_responder_pkg;

    // Access size, func3[1:0] encoding
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_lane_align                                              |
// | Description : Combinational byte-lane steering: store strobes, replicated  |
// |               write data, shifted load data and misalignment flag.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_raw,
    output logic [3:0]  o_strobe,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_shift,
    output logic        o_misalign
);

    always_comb begin
        o_strobe    = 4'b0000;
        o_wdata_rep = i_wdata;
        o_misalign  = 1'b0;
        case (i_size)
            SZ_B: begin
                o_strobe    = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_strobe    = 4'b0011 << i_addr_lo;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_misalign  = i_addr_lo[0];
            end
            SZ_W: begin
                o_strobe    = 4'b1111;
                o_misalign  = (i_addr_lo != 2'b00);
            end
            default: o_misalign = 1'b1;
        endcase
    end

    // Upper bits keep the raw neighbouring lanes; no sign/zero extension here
    assign o_rdata_shift = i_rdata_raw >> {i_addr_lo, 3'b000};

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Latency-tolerant, misalignment-checking data-memory slave    |
// |               with valid/ready request and response channels.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_depth = 32'(DEPTH);
    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [31:0] r_mem [DEPTH];

    logic [c_aw-1:0] w_idx;
    logic [31:0]     w_rdata_raw;
    logic [3:0]      w_strobe;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_rdata_shift;
    logic            w_misalign;
    logic            w_in_range;
    logic            w_err;
    logic            w_access;
    logic            w_do_write;

    assign w_idx       = r_addr[c_aw+1:2];
    assign w_rdata_raw = r_mem[w_idx];
    assign w_in_range  = ({2'b00, r_addr[31:2]} < c_depth);
    assign w_err       = w_misalign | ~w_in_range;
    assign w_access    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_do_write  = w_access && r_write && !w_err;

    dmem_lane_align u_align (
        .i_size        (r_size),
        .i_addr_lo     (r_addr[1:0]),
        .i_wdata       (r_wdata),
        .i_rdata_raw   (w_rdata_raw),
        .o_strobe      (w_strobe),
        .o_wdata_rep   (w_wdata_rep),
        .o_rdata_shift (w_rdata_shift),
        .o_misalign    (w_misalign)
    );

    // Array is deliberately not reset; only the access edge can write it
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strobe[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_size      <= SZ_B;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_wait;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rdata_shift;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for MEM-stage load/store traffic. It accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs a byte-lane-correct access to an internal word array and returns the result over a second valid/ready handshake. It sits between the MEM stage's load/store path and on-chip data RAM, and replaces the single-cycle array with a latency-tolerant, misalignment-checking slave.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words in the array.
- WAIT_CYCLES, 2: wait states between accept and access; legal range 0..15.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept; equals (state == IDLE).
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved (func3[1:0] encoding).
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-justified.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: requester accepts response.
- rsp_rdata, output, 32: load data shifted to bits [7:0]/[15:0]/[31:0]; upper bits are raw neighbouring lanes; 0 for stores and errors.
- rsp_err, output, 1: request rejected (misaligned, reserved size, or out of range).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, on req_valid & req_ready:
  - Latch write, size, addr and wdata.
  - Compute err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - Load cnt = WAIT_CYCLES and go to WAIT.
- WAIT, cnt != 0: cnt decrements; no other effect.
- WAIT, cnt == 0: perform the access on this edge (unless err) and go to RESP.
- Stores update only the strobed lanes:
  - Byte: strobe = 1 << addr[1:0]; lane data = {4{wdata[7:0]}}.
  - Half: strobe = 0011 << addr[1:0]; lane data = {2{wdata[15:0]}}.
  - Word: strobe = 1111; lane data = wdata.
- Loads: rsp_rdata = mem[addr[31:2]] >> (8*addr[1:0]), registered on the access edge.
- Errors: no array write; rsp_rdata = 0; rsp_err = 1.
- RESP: rsp_valid = 1 and outputs held stable until rsp_valid & rsp_ready; then return to IDLE.
- No pipelining: req_ready = 0 in WAIT and RESP.
- The array is not reset; contents are undefined until written.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, cnt = 0.
- Accept edge E0:
  - Access occurs on edge E(WAIT_CYCLES+1).
  - rsp_valid is high from that edge onward.
  - With WAIT_CYCLES = 0, rsp_valid is high in the cycle after E0.
- Latency is identical for errors and good requests.
- Response handshake edge: rsp_valid falls and state = IDLE on that edge.
- The next accept is possible no earlier than the following edge. The minimum request period is WAIT_CYCLES+3 cycles when rsp_ready is held high.
- A store in flight is committed exactly once, on the access edge. Back-pressure on rsp_ready never repeats it.
- rst asserted mid-transaction:
  - Immediate return to IDLE; outputs go to reset values.
  - A store whose access edge has not occurred is dropped.
- req_* inputs are ignored outside IDLE.

## Structure
- Shared header/package (alongside define.vh): size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10; FSM state encodings.
- Sub-module dmem_lane_align (combinational) covers:
  - Inputs: size, addr[1:0], wdata, raw read word.
  - Outputs: 4-bit strobe, replicated write data, shifted read data, and the misalignment flag.
- Top level holds the FSM, wait counter, request latch, array and response registers.

## Test plan
- Word store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF at 0x10, then load 0x10.
  - Required: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after each accept edge.
- Byte merge:
  - Word 0x00000000 at 0x20; store byte 0xAB at 0x22; load word 0x20.
  - Required: 0x00AB0000. Then load byte 0x22; required: rsp_rdata[7:0]=0xAB.
- Misalignment:
  - Half store at 0x31, word load at 0x42, and size=11 at 0x40.
  - Required: each gives rsp_err=1, rsp_rdata=0; array at 0x30 unchanged.
- Out of range:
  - Word store at byte address 4*DEPTH.
  - Required: rsp_err=1; no write.
- Back-pressure and throughput:
  - Hold rsp_ready=0 for 5 cycles on a store.
  - Required: rsp_valid and outputs stable, req_ready=0, store committed once.
  - With rsp_ready=1 and WAIT_CYCLES=0, back-to-back accepts occur every 3 cycles.
- Reset mid-operation:
  - Assert rst during WAIT of a store to 0x50 (prior value 0x11111111).
  - Required: rsp_valid=0 and req_ready=1 immediately; a later load of 0x50 returns 0x11111111.
